// File: rtl/ifmap_stream_loader.sv
// Stream-to-SRAM loader for the ifmap scratchpad: writes a valid/ready word stream into a
// circular buffer and tracks occupancy against entries released by the address generator.
module ifmap_stream_loader #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    // "release" is a reserved word, hence the suffix
    input  logic                  release_req,
    output logic [ADDR_WIDTH-1:0] sram_waddr,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic                  sram_wen,
    output logic                  sram_cen,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FIN
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [LEN_WIDTH-1:0]  words;
    logic                  accept;
    logic                  rel_ok;

    assign full     = (count == DEPTH);
    assign empty    = (count == '0);
    assign in_ready = (state == LOAD) && !full;
    assign accept   = in_valid && in_ready;
    assign rel_ok   = release_req && !empty;
    assign sram_cen = sram_wen;
    assign done     = (state == FIN);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len != '0) ? LOAD : FIN;
                end
            end
            LOAD: begin
                if (accept && (words == LEN_WIDTH'(1))) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            words      <= '0;
            sram_wen   <= 1'b0;
            sram_waddr <= '0;
            sram_din   <= '0;
        end else begin
            state    <= state_next;
            sram_wen <= accept;
            if (accept) begin
                sram_waddr <= wr_ptr;
                sram_din   <= in_data;
                wr_ptr     <= wr_ptr + 1'b1;
            end
            if (rel_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !rel_ok) begin
                count <= count + 1'b1;
            end else if (!accept && rel_ok) begin
                count <= count - 1'b1;
            end
            if ((state == IDLE) && start) begin
                words <= len;
            end else if (accept) begin
                words <= words - 1'b1;
            end
        end
    end

endmodule
